simon_96144: RTL and testbench

- Iterative SIMON 96/144 block-cipher core: 96-bit block as two 48-bit words, 144-bit key as three 48-bit words, 54 rounds.
- On request, expands the key into a stored 54-entry round-key table. It then encrypts or decrypts one block at a time, one round per clock.
- Data moves through a level handshake (newData/loadData, doneData/readData). It sits between a host data/key source and a result consumer.

---
 rtl/simon_96144_pkg.sv | 30 +++
 rtl/simon_96144_if.sv | 28 ++
 rtl/simon_96144_key_expand.sv | 59 +++++
 rtl/simon_96144.sv | 101 ++++++++++
 tb/tb_simon_96144.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simon_96144_pkg.sv
// Shared constants, state codes and bit-rotation helpers for the SIMON 96/144 core.
package simon_pkg;

  localparam int N  = 48;
  localparam int M  = 3;
  localparam int T  = 54;
  localparam int Co = 6;

  // z3 sequence, bit 0 is the first element used by the key schedule
  localparam logic [61:0] Z3 = 62'h3C2CE51207A635DB;

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] KEYEXP = 4'd1;
  localparam logic [3:0] ENC    = 4'd2;
  localparam logic [3:0] DEC    = 4'd3;
  localparam logic [3:0] DONE   = 4'd4;

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
    return (v >> s) | (v << (N - s));
  endfunction

  function automatic logic [N-1:0] f(input logic [N-1:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

endpackage

// File: rtl/simon_96144_if.sv
// Host-side handshake and data bus of the SIMON 96/144 core.
interface simon_96144_if;
  import simon_pkg::*;

  logic                  newData;
  logic                  newKey;
  logic                  enc_dec;
  logic                  readData;
  logic [1:0][N-1:0]     inData;
  logic [M-1:0][N-1:0]   key;
  logic                  loadData;
  logic                  loadKey;
  logic                  doneData;
  logic                  doneKey;
  logic [1:0][N-1:0]     outData;
  logic [3:0]            mode;

  modport master (
    output newData, newKey, enc_dec, readData, inData, key,
    input  loadData, loadKey, doneData, doneKey, outData, mode
  );

  modport slave (
    input  newData, newKey, enc_dec, readData, inData, key,
    output loadData, loadKey, doneData, doneKey, outData, mode
  );

endinterface

// File: rtl/simon_96144_key_expand.sv
// Round-key table: captures the three key words, then derives one further round key per clock.
module simon_key_expand
  import simon_pkg::*;
(
  input  logic                clk,
  input  logic                nR,
  input  logic                start,
  input  logic [M-1:0][N-1:0] key,
  input  logic [Co-1:0]       rdIdx,
  output logic [N-1:0]        rdKey,
  output logic                lastStep,
  output logic                doneKey
);

  logic [N-1:0]  rk [T];
  logic [Co-1:0] step;
  logic          busy;
  logic [N-1:0]  tmp;
  logic [N-1:0]  nextKey;

  always_comb begin
    tmp     = ror(rk[step + Co'(2)], 3);
    tmp     = tmp ^ ror(tmp, 1);
    nextKey = ~rk[step] ^ tmp ^ {{(N-1){1'b0}}, Z3[step]} ^ N'(3);
  end

  assign lastStep = busy && (step == Co'(T - 4));
  assign rdKey    = rk[rdIdx];

  always_ff @(posedge clk) begin
    if (!nR) begin
      step    <= '0;
      busy    <= 1'b0;
      doneKey <= 1'b0;
    end else if (start) begin
      step    <= '0;
      busy    <= 1'b1;
      doneKey <= 1'b0;
    end else if (busy) begin
      step <= step + Co'(1);
      if (lastStep) begin
        busy    <= 1'b0;
        doneKey <= 1'b1;
      end
    end
  end

  // Table contents are qualified by doneKey, so they need no reset
  always_ff @(posedge clk) begin
    if (start) begin
      rk[0] <= key[0];
      rk[1] <= key[1];
      rk[2] <= key[2];
    end else if (busy) begin
      rk[step + Co'(3)] <= nextKey;
    end
  end

endmodule

// File: rtl/simon_96144.sv
// Iterative SIMON 96/144 core: control FSM, round datapath and host handshake.
module simon_96144
  import simon_pkg::*;
(
  input logic          clk,
  input logic          nR,
  simon_96144_if.slave bus
);

  logic [3:0]    state;
  logic [Co-1:0] round;
  logic [N-1:0]  x;
  logic [N-1:0]  y;
  logic [Co-1:0] rdIdx;
  logic [N-1:0]  rdKey;
  logic          keyStart;
  logic          keyLast;
  logic          keyValid;

  assign keyStart    = (state == IDLE) && bus.newKey;
  assign bus.doneKey = keyValid;
  assign bus.mode    = state;

  // Decryption walks the round-key table backwards
  always_comb begin
    rdIdx = round;
    if (round >= Co'(T))
      rdIdx = '0;
    else if (state == DEC)
      rdIdx = Co'(T - 1) - round;
  end

  simon_key_expand keyExpand (
    .clk      (clk),
    .nR       (nR),
    .start    (keyStart),
    .key      (bus.key),
    .rdIdx    (rdIdx),
    .rdKey    (rdKey),
    .lastStep (keyLast),
    .doneKey  (keyValid)
  );

  always_ff @(posedge clk) begin
    if (!nR) begin
      state        <= IDLE;
      round        <= '0;
      x            <= '0;
      y            <= '0;
      bus.outData  <= '0;
      bus.loadData <= 1'b0;
      bus.loadKey  <= 1'b0;
      bus.doneData <= 1'b0;
    end else begin
      bus.loadData <= 1'b0;
      bus.loadKey  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.newKey) begin
            bus.loadKey <= 1'b1;
            state       <= KEYEXP;
          end else if (bus.newData && keyValid) begin
            x            <= bus.inData[1];
            y            <= bus.inData[0];
            round        <= '0;
            bus.loadData <= 1'b1;
            state        <= bus.enc_dec ? ENC : DEC;
          end
        end
        KEYEXP: begin
          if (keyLast)
            state <= IDLE;
        end
        ENC, DEC: begin
          if (round == Co'(T)) begin
            bus.outData  <= {x, y};
            bus.doneData <= 1'b1;
            state        <= DONE;
          end else begin
            round <= round + Co'(1);
            if (state == ENC) begin
              x <= y ^ f(x) ^ rdKey;
              y <= x;
            end else begin
              y <= x ^ f(y) ^ rdKey;
              x <= y;
            end
          end
        end
        DONE: begin
          if (bus.readData) begin
            bus.doneData <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_96144.sv
// Scoreboard bench for the SIMON 96/144 core against a loop-based reference of the cipher.
module tb_simon_96144;

  logic clk = 1'b0;
  logic nR  = 1'b0;
  always #5 clk = ~clk;

  simon_96144_if bus();

  simon_96144 dut (
    .clk (clk),
    .nR  (nR),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [95:0]  expQ[$];
  logic [95:0]  capQ[$];
  logic [47:0]  mrk[54];
  logic         prevDone = 1'b0;
  logic [95:0]  reqBlk;
  bit           reqEnc;

  localparam string Z3S = "11011011101011000110010111100000010010001010011100110100001111";
  localparam logic [143:0] KEY0 = 144'h151413121110_0D0C0B0A0908_050403020100;
  localparam logic [95:0]  PT0  = 96'h746168742074_73756420666F;
  localparam logic [95:0]  CT0  = 96'hECAD1C6C451E_3F59C5DB1AE9;

  function automatic logic [47:0] rl(logic [47:0] v, int s);
    return (v << s) | (v >> (48 - s));
  endfunction

  function automatic logic [47:0] rr(logic [47:0] v, int s);
    return rl(v, 48 - s);
  endfunction

  function automatic logic [47:0] fm(logic [47:0] v);
    return (rl(v, 1) & rl(v, 8)) ^ rl(v, 2);
  endfunction

  function automatic void modelKey(logic [143:0] k);
    logic [47:0] t;
    mrk[0] = k[47:0];
    mrk[1] = k[95:48];
    mrk[2] = k[143:96];
    for (int i = 0; i < 51; i++) begin
      t = rr(mrk[i+2], 3);
      t = t ^ rr(t, 1);
      mrk[i+3] = ~mrk[i] ^ t ^ ((Z3S[i] == "1") ? 48'd1 : 48'd0) ^ 48'd3;
    end
  endfunction

  function automatic logic [95:0] modelCipher(logic [95:0] b, bit enc);
    logic [47:0] x, y, t;
    x = b[95:48];
    y = b[47:0];
    for (int r = 0; r < 54; r++) begin
      if (enc) begin
        t = x;
        x = y ^ fm(x) ^ mrk[r];
        y = t;
      end else begin
        t = y;
        y = x ^ fm(y) ^ mrk[53-r];
        x = t;
      end
    end
    return {x, y};
  endfunction

  function automatic logic [127:0] outs();
    return {24'd0, bus.loadData, bus.loadKey, bus.doneData, bus.doneKey, bus.outData, bus.mode};
  endfunction

  task automatic checkOutput(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rising doneData consumes one expected result
  always @(negedge clk) begin
    if (nR && bus.doneData && !prevDone) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpectedDone: got %h, expected no result", bus.outData);
      end else begin
        checkOutput("outData", 128'(bus.outData), 128'(expQ.pop_front()));
      end
      capQ.push_back(bus.outData);
    end
    if (nR && bus.loadData)
      checkOutput("loadAfterRead", 128'(prevDone), 128'd0);
    prevDone = bus.doneData;
  end

  task automatic waitKey();
    int n = 0;
    while (!bus.doneKey && n < 80) begin
      @(negedge clk);
      n++;
    end
    checkOutput("keyLatency", 128'(n), 128'd51);
  endtask

  task automatic applyStimulus(logic [143:0] k);
    int n = 0;
    bus.key    = k;
    bus.newKey = 1'b1;
    while (!bus.loadKey && n < 200) begin
      @(negedge clk);
      n++;
    end
    bus.newKey = 1'b0;
    checkOutput("loadKeySeen", 128'(bus.loadKey), 128'd1);
    modelKey(k);
    waitKey();
  endtask

  task automatic requestBlock(logic [95:0] b, bit enc);
    bus.inData  = b;
    bus.enc_dec = enc;
    bus.newData = 1'b1;
    reqBlk      = b;
    reqEnc      = enc;
  endtask

  task automatic waitLoad(output bit ok);
    int n = 0;
    while (!bus.loadData && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = bus.loadData;
    bus.newData = 1'b0;
  endtask

  task automatic acceptBlock(logic [95:0] exp, bit useModel);
    bit ok;
    int n = 0;
    waitLoad(ok);
    if (!ok) begin
      checkOutput("loadTimeout", 128'd0, 128'd1);
      return;
    end
    expQ.push_back(useModel ? modelCipher(reqBlk, reqEnc) : exp);
    while (!bus.doneData && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("dataLatency", 128'(n), 128'd55);
  endtask

  task automatic readOut(int d);
    repeat (d) @(negedge clk);
    bus.readData = 1'b1;
    @(negedge clk);
    bus.readData = 1'b0;
  endtask

  task automatic resetCheck(string name);
    nR = 1'b0;
    @(negedge clk);
    checkOutput(name, outs(), 128'd0);
    nR = 1'b1;
  endtask

  task automatic noLoadWindow(string name, int cycles);
    int loads = 0;
    bus.newData = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.loadData) loads++;
    end
    bus.newData = 1'b0;
    checkOutput(name, 128'(loads), 128'd0);
  endtask

  initial begin
    logic [95:0]  pts[5];
    logic [95:0]  cts[5];
    logic [95:0]  held;
    logic [143:0] k;
    bit           ok;
    int           bad;
    int           loads;

    bus.newData  = 1'b0;
    bus.newKey   = 1'b0;
    bus.enc_dec  = 1'b0;
    bus.readData = 1'b0;
    bus.inData   = '0;
    bus.key      = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetOutputs", outs(), 128'd0);
    nR = 1'b1;

    // Known-answer encrypt and decrypt
    applyStimulus(KEY0);
    requestBlock(PT0, 1'b1);
    acceptBlock(CT0, 1'b0);
    readOut(1);
    requestBlock(CT0, 1'b0);
    acceptBlock(PT0, 1'b0);
    readOut(0);

    // Stream with newData raised while the previous result is pending
    pts[0] = PT0;
    pts[1] = 96'hA8D5F7DE0123_FEDC01234567;
    pts[2] = 96'h5BC92D014567_BA9889ABCDEF;
    pts[3] = 96'hF2B48D4589AB_765401234567;
    pts[4] = 96'h567F11DECDEF_321089ABCDEF;
    capQ.delete();
    requestBlock(pts[0], 1'b1);
    acceptBlock('0, 1'b1);
    for (int b = 1; b < 5; b++) begin
      requestBlock(pts[b], 1'b1);
      readOut(3);
      acceptBlock('0, 1'b1);
    end
    readOut(3);
    checkOutput("streamCount", 128'(capQ.size()), 128'd5);
    for (int b = 0; b < 5; b++) cts[b] = (b < capQ.size()) ? capQ[b] : '0;
    for (int b = 0; b < 5; b++) begin
      requestBlock(cts[b], 1'b0);
      acceptBlock(pts[b], 1'b0);
      readOut(0);
    end

    // Random keys and blocks in both directions
    for (int kk = 0; kk < 2; kk++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
      applyStimulus(k);
      for (int j = 0; j < 3; j++) begin
        requestBlock({$urandom(), $urandom(), $urandom()}, 1'($urandom_range(0, 1)));
        acceptBlock('0, 1'b1);
        readOut($urandom_range(0, 4));
      end
    end

    // Result held while readData is withheld
    requestBlock({$urandom(), $urandom(), $urandom()}, 1'b1);
    acceptBlock('0, 1'b1);
    held = bus.outData;
    requestBlock({$urandom(), $urandom(), $urandom()}, 1'b0);
    bad   = 0;
    loads = 0;
    repeat (100) begin
      @(negedge clk);
      if (!bus.doneData || bus.outData !== held) bad++;
      if (bus.loadData) loads++;
    end
    checkOutput("holdStable", 128'(bad), 128'd0);
    checkOutput("noLoadWhileDone", 128'(loads), 128'd0);
    readOut(0);
    acceptBlock('0, 1'b1);
    readOut(0);

    // Reset in the middle of a round sequence
    requestBlock({$urandom(), $urandom(), $urandom()}, 1'b1);
    waitLoad(ok);
    checkOutput("loadBeforeRst", 128'(ok), 128'd1);
    repeat (20) @(negedge clk);
    resetCheck("rstMidRound");
    noLoadWindow("noLoadAfterRst", 30);

    // Reset in the middle of key expansion
    applyStimulus(KEY0);
    bus.key    = KEY0 ^ 144'h1;
    bus.newKey = 1'b1;
    @(negedge clk);
    checkOutput("loadKeyPulse", 128'(bus.loadKey), 128'd1);
    bus.newKey = 1'b0;
    repeat (10) @(negedge clk);
    resetCheck("rstMidKeyExp");
    noLoadWindow("noLoadAfterKeyRst", 60);

    // newKey and newData together: key wins, block follows expansion
    k = {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
    bus.key = k;
    requestBlock({$urandom(), $urandom(), $urandom()}, 1'b1);
    bus.newKey = 1'b1;
    loads = 0;
    while (!bus.loadKey && !bus.loadData && loads < 20) begin
      @(negedge clk);
      loads++;
    end
    checkOutput("keyFirst", 128'({bus.loadKey, bus.loadData}), 128'd2);
    bus.newKey = 1'b0;
    modelKey(k);
    waitKey();
    acceptBlock('0, 1'b1);
    readOut(0);
    repeat (3) @(negedge clk);
    checkOutput("scoreboardEmpty", 128'(expQ.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
